// File: rtl/bcd_pkg.sv
// Shared types, widths and the BCD ripple step for the four-digit counter.
// Pure combinational helpers only; no state.
package bcd_pkg;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_e;

  localparam int               BCD_W    = 4;
  localparam logic [BCD_W-1:0] BCD_MAX  = 4'd9;
  localparam int               N_DIGITS = 4;
  localparam int               DIG_W    = BCD_W * N_DIGITS;

  // Returns {wrap, next_digits}; the carry/borrow out of the top digit is the wrap.
  function automatic logic [DIG_W:0] bcd_step(input logic [DIG_W-1:0] cur, input logic count_up);
    logic [DIG_W-1:0] nxt;
    logic [BCD_W-1:0] dig;
    logic             carry;
    nxt   = cur;
    carry = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      dig = cur[i*BCD_W +: BCD_W];
      if (carry) begin
        if (count_up) begin
          if (dig >= BCD_MAX) begin
            dig = '0;
          end else begin
            dig   = dig + 1'b1;
            carry = 1'b0;
          end
        end else begin
          if (dig == '0) begin
            dig = BCD_MAX;
          end else begin
            dig   = dig - 1'b1;
            carry = 1'b0;
          end
        end
      end
      nxt[i*BCD_W +: BCD_W] = dig;
    end
    return {carry, nxt};
  endfunction

endpackage

// File: rtl/bcd_counter_btn_debounce.sv
// Pushbutton qualifier: 2-flop sync, stability counter, one-cycle press pulse on accepted 1->0.
// Latency 2 + DEBOUNCE_CYC cycles to acceptance, pulse one edge later; no backpressure.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  localparam int            CW       = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          armed_q, armed_d;
  logic          press_q, press_d;
  logic [1:0]    fill_q,  fill_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  // A press only counts once a genuine released level has been seen since reset,
  // so a button held through reset cannot fire on its own.
  always_comb begin
    sync1_d = btn_n;
    sync2_d = sync1_q;
    fill_d  = {fill_q[0], 1'b1};
    armed_d = armed_q | (fill_q[1] & sync2_q);
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = armed_q & ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      armed_q <= 1'b0;
      press_q <= 1'b0;
      fill_q  <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      armed_q <= armed_d;
      press_q <= press_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/bcd_counter.sv
// Four-digit BCD up/down counter with start/stop and clear buttons for the seven-segment display.
// One count per TICK_DIV cycles while running; digits/wrap registered; no backpressure.
module bcd_counter
  import bcd_pkg::*;
#(
  parameter int TICK_DIV     = 5_000_000,
  parameter int DEBOUNCE_CYC = 500_000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_stop_n,
  input  logic                      clear_n,
  input  logic                      up,
  output logic [N_DIGITS*BCD_W-1:0] digits,
  output logic                      running,
  output logic                      wrap
);

  localparam int            PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic             ss_press;
  logic             clr_press;
  logic             up_s1_q,  up_s1_d;
  logic             up_s2_q,  up_s2_d;
  state_e           state_q,  state_d;
  logic [PW-1:0]    presc_q,  presc_d;
  logic [DIG_W-1:0] digits_q, digits_d;
  logic             wrap_q,   wrap_d;
  logic             step;
  logic [DIG_W:0]   ripple;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_ss_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (start_stop_n),
    .press (ss_press)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_clr_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (clear_n),
    .press (clr_press)
  );

  assign step   = (state_q == RUNNING) && (presc_q == PRESC_LAST);
  assign ripple = bcd_step(digits_q, up_s2_q);

  always_comb begin
    up_s1_d  = up;
    up_s2_d  = up_s1_q;
    state_d  = state_q;
    presc_d  = presc_q;
    digits_d = digits_q;
    wrap_d   = 1'b0;
    // Prescaler freezes while stopped so a pause/resume keeps the tick phase.
    if (state_q == RUNNING) begin
      presc_d = step ? '0 : presc_q + 1'b1;
    end
    if (step) begin
      digits_d = ripple[DIG_W-1:0];
      wrap_d   = ripple[DIG_W];
    end
    if (ss_press) begin
      state_d = (state_q == RUNNING) ? STOPPED : RUNNING;
    end
    if (clr_press) begin
      state_d  = STOPPED;
      presc_d  = '0;
      digits_d = '0;
      wrap_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_s1_q  <= 1'b1;
      up_s2_q  <= 1'b1;
      state_q  <= STOPPED;
      presc_q  <= '0;
      digits_q <= '0;
      wrap_q   <= 1'b0;
    end else begin
      up_s1_q  <= up_s1_d;
      up_s2_q  <= up_s2_d;
      state_q  <= state_d;
      presc_q  <= presc_d;
      digits_q <= digits_d;
      wrap_q   <= wrap_d;
    end
  end

  assign digits  = digits_q;
  assign running = (state_q == RUNNING);
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_bcd_counter.sv
// Bench for bcd_counter with TICK_DIV=4, DEBOUNCE_CYC=3: step table, random direction walk
// against an integer model, and hand sequences for buttons, clear priority and reset.
module tb_bcd_counter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_stop_n;
  logic        clear_n;
  logic        up;
  logic [15:0] digits;
  logic        running;
  logic        wrap;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic        dir;
    int          steps;
    logic [15:0] exp_dig;
    logic        exp_wrap;
  } vec_t;

  vec_t tbl[15];

  bcd_counter #(.TICK_DIV(4), .DEBOUNCE_CYC(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_stop_n (start_stop_n),
    .clear_n      (clear_n),
    .up           (up),
    .digits       (digits),
    .running      (running),
    .wrap         (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  // Hold the chosen buttons for six cycles, then release; returns at the negedge
  // where the press effect first becomes visible.
  task automatic press(input logic ss, input logic clr);
    if (ss)  start_stop_n = 1'b0;
    if (clr) clear_n      = 1'b0;
    repeat (6) @(negedge clk);
    start_stop_n = 1'b1;
    clear_n      = 1'b1;
  endtask

  initial begin
    int   val;
    int   rc;
    logic h1, h2, cur, ew;

    tbl[0]  = '{1'b1, 1,   16'h0001, 1'b0};
    tbl[1]  = '{1'b1, 2,   16'h0003, 1'b0};
    tbl[2]  = '{1'b0, 3,   16'h0000, 1'b0};
    tbl[3]  = '{1'b0, 1,   16'h9999, 1'b1};
    tbl[4]  = '{1'b0, 1,   16'h9998, 1'b0};
    tbl[5]  = '{1'b0, 1,   16'h9997, 1'b0};
    tbl[6]  = '{1'b1, 2,   16'h9999, 1'b0};
    tbl[7]  = '{1'b1, 1,   16'h0000, 1'b1};
    tbl[8]  = '{1'b0, 1,   16'h9999, 1'b1};
    tbl[9]  = '{1'b1, 1,   16'h0000, 1'b1};
    tbl[10] = '{1'b1, 998, 16'h0998, 1'b0};
    tbl[11] = '{1'b1, 1,   16'h0999, 1'b0};
    tbl[12] = '{1'b1, 1,   16'h1000, 1'b0};
    tbl[13] = '{1'b0, 1,   16'h0999, 1'b0};
    tbl[14] = '{1'b0, 999, 16'h0000, 1'b0};

    rst_n        = 1'b0;
    start_stop_n = 1'b1;
    clear_n      = 1'b1;
    up           = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_digits", digits, 16'h0000);
    chk("reset_running", running, 1'b0);
    chk("reset_wrap", wrap, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Held start button: one toggle, then counting at 4-cycle intervals.
    start_stop_n = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (c == 5)  chk("run_before_accept", running, 1'b0);
      if (c == 6)  chk("run_after_accept", running, 1'b1);
      if (c == 9)  chk("dig_before_first_step", digits, 16'h0000);
      if (c == 10) begin
        chk("dig_step1", digits, 16'h0001);
        start_stop_n = 1'b1;
      end
      if (c == 14) chk("dig_step2", digits, 16'h0002);
      if (c == 18) chk("dig_step3", digits, 16'h0003);
    end
    chk("hold_single_toggle", running, 1'b1);

    for (int c = 0; c < 8; c++) begin
      start_stop_n = (c % 2) != 0;
      @(negedge clk);
    end
    start_stop_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("bounce_no_toggle", running, 1'b1);

    press(1'b0, 1'b1);
    chk("clear_running", running, 1'b0);
    chk("clear_digits", digits, 16'h0000);
    press(1'b1, 1'b0);
    chk("restart_running", running, 1'b1);

    // Step table: each record is aligned to the negedge just after a step edge.
    for (int i = 0; i < 15; i++) begin
      up = tbl[i].dir;
      @(negedge clk);
      chk($sformatf("tbl%0d_wrap_low", i), wrap, 1'b0);
      repeat (4 * tbl[i].steps - 1) @(negedge clk);
      chk($sformatf("tbl%0d_digits", i), digits, tbl[i].exp_dig);
      chk($sformatf("tbl%0d_wrap", i), wrap, tbl[i].exp_wrap);
    end

    // Random direction walk against an integer model; up reaches the counter two edges late.
    val = 0;
    rc  = 0;
    h1  = 1'b0;
    h2  = 1'b0;
    ew  = 1'b0;
    for (int n = 0; n < 300; n++) begin
      chk("rand_digits", digits, to_bcd(val));
      chk("rand_wrap", wrap, ew);
      cur = ($urandom_range(0, 5) == 0) ? ~h1 : h1;
      up  = cur;
      @(posedge clk);
      rc++;
      ew = 1'b0;
      if (rc % 4 == 0) begin
        if (h2) begin
          ew  = (val == 9999);
          val = (val + 1) % 10000;
        end else begin
          ew  = (val == 0);
          val = (val + 9999) % 10000;
        end
      end
      h2 = h1;
      h1 = cur;
      @(negedge clk);
    end
    chk("rand_final", digits, to_bcd(val));

    press(1'b1, 1'b1);
    chk("clr_ss_running", running, 1'b0);
    chk("clr_ss_digits", digits, 16'h0000);
    chk("clr_ss_wrap", wrap, 1'b0);
    up = 1'b1;
    repeat (8) @(negedge clk);
    press(1'b1, 1'b0);
    chk("resume_running", running, 1'b1);
    repeat (3) @(negedge clk);
    chk("presc_cleared_no_early_step", digits, 16'h0000);
    @(negedge clk);
    chk("presc_cleared_step", digits, 16'h0001);

    // Reset mid-debounce while counting, with the button still held afterwards.
    start_stop_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_digits", digits, 16'h0000);
    chk("async_rst_running", running, 1'b0);
    chk("async_rst_wrap", wrap, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("held_through_reset_no_press", running, 1'b0);
    start_stop_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("release_no_press", running, 1'b0);
    press(1'b1, 1'b0);
    chk("press_after_rearm", running, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
